uart_tx_fifo_core: RTL and testbench
====================================

# uart_tx_fifo_core

Parametrised UART transmitter that replaces the fixed 8N1 sender. It adds a compile-time clock/baud pair, a selectable data width, run-time parity and stop-bit selection, and a small transmit FIFO with a valid/ready push port. Frames are sent back-to-back without CPU pacing. It sits between the control-board command logic and the board's TXD pin, in the same clock domain as the rest of the control logic.

## Interface
Parameters:
- CLK_FREQ, 100_000_000: system clock in Hz.
- BAUD, 2_500_000: line rate. BPS_CNT = CLK_FREQ/BAUD, integer-truncated; BPS_CNT < 2 is an elaboration error.
- DATA_BITS, 8: data bits per frame, 5..8.
- FIFO_DEPTH, 4: transmit FIFO depth, power of two, ≥2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- tx_data, in, 8: byte to push. Only bits [DATA_BITS-1:0] are transmitted.
- tx_valid, in, 1: push request.
- tx_ready, out, 1: FIFO not full. A word is accepted on a rising edge where tx_valid && tx_ready.
- parity_mode, in, 2: 00 none, 01 odd, 10 even, 11 none.
- stop_two, in, 1: 1 selects two stop bits.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: number of words held.
- tx_busy, out, 1: FSM not in IDLE.
- uart_txd, out, 1: serial output, registered.

## Operation
- Reset values: uart_txd=1, tx_busy=0, fifo_level=0, tx_ready=1; FIFO is empty and the FSM is in IDLE.
- FSM states: IDLE → START → DATA → PARITY (skipped when parity is none) → STOP → IDLE, or → START directly if the FIFO is non-empty at the end of STOP.
- Pop: in IDLE, or on the last cycle of STOP, with the FIFO non-empty, pop one word. On the same edge, latch the word, parity_mode and stop_two. Changes to these inputs mid-frame have no effect on the current frame.
- Line levels:
  - START drives 0.
  - DATA drives bits LSB first, bit index 0..DATA_BITS-1.
  - PARITY drives ^data for even, ~^data for odd, computed over the DATA_BITS transmitted bits only.
  - STOP drives 1 for 1 or 2 bit periods.
- Every bit period lasts exactly BPS_CNT clocks. The baud counter runs 0..BPS_CNT-1 and clears on each state/bit advance. The bit counter counts 0..DATA_BITS-1 in DATA and 0..1 in STOP.
- FIFO behaviour:
  - Push while full: tx_ready=0, so the word is not accepted and the data is ignored.
  - Push and pop on the same edge: fifo_level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level saturates at FIFO_DEPTH by construction.
- Reset mid-frame: uart_txd returns to 1 asynchronously, and FIFO contents are discarded.

## Timing
- A word accepted at edge N into an empty FIFO with the FSM in IDLE:
  - popped at edge N+1;
  - uart_txd falls at edge N+2;
  - tx_busy rises at edge N+1.
- Frame length = (1 + DATA_BITS + P + S) × BPS_CNT clocks, where P = 1 if parity is enabled and S = 1 or 2.
- Back-to-back frames have zero idle clocks: the next start bit begins on the edge after the final stop-bit clock.
- tx_busy falls on the edge that ends the last stop bit when the FIFO is empty. uart_txd stays 1 thereafter.
- tx_ready and fifo_level are registered-state derived, with no combinational path from tx_valid.

## Structure
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - the FSM state enum;
  - the function computing BPS_CNT and the baud counter width.
- Sub-module uart_tx_fifo provides synchronous single-clock FIFO storage, pointers, level, full/empty. It is instantiated once.
- The top level contains the FSM, baud counter, bit counter, shift register and parity generator.

## Test plan
All scenarios use defaults (BPS_CNT=40) unless stated.
- 8N1: push 0x55 → uart_txd holds 0,1,0,1,0,1,0,1,0,1, each for exactly 40 clocks. Start bit falls 2 edges after acceptance. tx_busy is high for 400 clocks.
- Parity: push 0x07 with parity_mode=10 → parity bit 1; with parity_mode=01 → parity bit 0. Frame is 440 clocks. Toggling parity_mode mid-frame does not alter the frame in flight.
- DATA_BITS=7, stop_two=1: push 0xFF → start bit, 7 ones, then 2 stop periods. Frame is 400 clocks. Bit 7 is never driven.
- FIFO full: hold tx_valid with 8 distinct words → 5 accepted on consecutive edges, then tx_ready=0 and fifo_level=4. tx_ready rises at the first frame's end. All 5 frames are emitted with zero idle gap, in push order.
- Reset mid-frame: assert rst_n=0 during DATA of the second of 3 queued frames → uart_txd=1 immediately, fifo_level=0, tx_busy=0. After release, nothing is transmitted until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: parity encodings,
// FSM states and the helpers that size the baud counter.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   function automatic int calc_bps_cnt(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

   // A counter for 0..n-1 needs at least one bit even when n is 2.
   function automatic int calc_cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_fifo_core_if.sv
// Valid/ready push port carrying bytes into the transmit FIFO.
interface uart_tx_fifo_core_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit FIFO: storage, wrapping pointers and a fill counter
// from which full/empty are derived.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [AW:0]      count_q, count_d;
   logic             pushOk, popOk;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign pushOk  = push_i && !full_o;
   assign popOk   = pop_i && !empty_o;
   assign rdata_o = mem_q[rdPtr_q];
   assign level_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
      if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
      case ({pushOk, popOk})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pushOk) mem_q[wrPtr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// UART transmitter fed by a small FIFO: sends frames back-to-back with
// per-frame parity and stop-bit settings captured when the word is popped.
module uart_tx_fifo_core
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 2_500_000,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   uart_tx_fifo_core_if.slave            push,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop_two,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          tx_busy,
   output logic                          uart_txd
);

   localparam int             BPS_CNT   = calc_bps_cnt(CLK_FREQ, BAUD);
   localparam int             BW        = calc_cnt_width(BPS_CNT);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BPS_CNT - 1);
   localparam logic [2:0]     LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [7:0]     DATA_MASK = 8'((1 << DATA_BITS) - 1);

   if (BPS_CNT < 2) begin : g_bad_bps
      $error("uart_tx_fifo_core: CLK_FREQ/BAUD must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
      $error("uart_tx_fifo_core: DATA_BITS must be 5..8");
   end

   tx_state_e       state_q, state_d;
   logic [BW-1:0]   baudCnt_q, baudCnt_d;
   logic [2:0]      bitCnt_q, bitCnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            parBit_q, parBit_d, parEn_q, parEn_d, stopTwo_q, stopTwo_d;
   logic            txd_q, txd_d;
   logic            bitTick, stopLast, pop, fifoEmpty, fifoFull;
   logic [7:0]      fifoRdata, wordMasked;

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push.tx_valid),
      .wdata_i (push.tx_data),
      .pop_i   (pop),
      .rdata_o (fifoRdata),
      .level_o (fifo_level),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty)
   );

   assign push.tx_ready = !fifoFull;
   assign bitTick       = (baudCnt_q == BAUD_LAST);
   assign stopLast      = (state_q == ST_STOP) && bitTick && (bitCnt_q == {2'b00, stopTwo_q});
   assign pop           = !fifoEmpty && ((state_q == ST_IDLE) || stopLast);
   assign wordMasked    = fifoRdata & DATA_MASK;
   assign uart_txd      = txd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (pop) state_d = ST_START;
         ST_START:  if (bitTick) state_d = ST_DATA;
         ST_DATA:   if (bitTick && bitCnt_q == LAST_DATA) state_d = parEn_q ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bitTick) state_d = ST_STOP;
         ST_STOP:   if (stopLast) state_d = pop ? ST_START : ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // The line level is registered, so it trails the state by one clock.
   always_comb begin
      tx_busy = (state_q != ST_IDLE);
      case (state_q)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_q[0];
         ST_PARITY: txd_d = parBit_q;
         default:   txd_d = 1'b1;
      endcase
   end

   always_comb begin
      baudCnt_d = (state_q == ST_IDLE || bitTick) ? '0 : baudCnt_q + 1'b1;
      bitCnt_d  = bitCnt_q;
      if (state_d != state_q)
         bitCnt_d = '0;
      else if (bitTick && (state_q == ST_DATA || state_q == ST_STOP))
         bitCnt_d = bitCnt_q + 1'b1;
      shift_d   = shift_q;
      parBit_d  = parBit_q;
      parEn_d   = parEn_q;
      stopTwo_d = stopTwo_q;
      if (pop) begin
         shift_d   = wordMasked;
         parEn_d   = (parity_mode == PAR_ODD) || (parity_mode == PAR_EVEN);
         parBit_d  = (parity_mode == PAR_EVEN) ? ^wordMasked : ~^wordMasked;
         stopTwo_d = stop_two;
      end else if (state_q == ST_DATA && bitTick) begin
         shift_d = shift_q >> 1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baudCnt_q <= '0;
         bitCnt_q  <= '0;
         shift_q   <= '0;
         parBit_q  <= 1'b0;
         parEn_q   <= 1'b0;
         stopTwo_q <= 1'b0;
         txd_q     <= 1'b1;
      end else begin
         baudCnt_q <= baudCnt_d;
         bitCnt_q  <= bitCnt_d;
         shift_q   <= shift_d;
         parBit_q  <= parBit_d;
         parEn_q   <= parEn_d;
         stopTwo_q <= stopTwo_d;
         txd_q     <= txd_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Directed bench for uart_tx_fifo_core: a default 8-bit instance and a
// 7-bit instance, checked clock by clock against hand-written frames.
module tb_uart_tx_fifo_core;

   localparam int BPS = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] parityMode, parityMode7;
   logic       stopTwo, stopTwo7;
   logic [2:0] fifoLevel, fifoLevel7;
   logic       txBusy, txBusy7, uartTxd, uartTxd7;
   logic [7:0] words [8];
   int         testsRun = 0;
   int         testsFailed = 0;

   uart_tx_fifo_core_if pushIf ();
   uart_tx_fifo_core_if pushIf7 ();

   always #5 clk = ~clk;

   uart_tx_fifo_core dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (pushIf),
      .parity_mode (parityMode),
      .stop_two    (stopTwo),
      .fifo_level  (fifoLevel),
      .tx_busy     (txBusy),
      .uart_txd    (uartTxd)
   );

   uart_tx_fifo_core #(.DATA_BITS(7)) dut7 (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (pushIf7),
      .parity_mode (parityMode7),
      .stop_two    (stopTwo7),
      .fifo_level  (fifoLevel7),
      .tx_busy     (txBusy7),
      .uart_txd    (uartTxd7)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic selTxd(input bit sel);
      return sel ? uartTxd7 : uartTxd;
   endfunction

   function automatic logic selBusy(input bit sel);
      return sel ? txBusy7 : txBusy;
   endfunction

   function automatic logic [2:0] selLevel(input bit sel);
      return sel ? fifoLevel7 : fifoLevel;
   endfunction

   // Start bit at b0, data LSB first, stop bit on top.
   function automatic logic [11:0] frameBits(input logic [7:0] d);
      return {2'b00, 1'b1, d, 1'b0};
   endfunction

   // Pushes one word; returns on the negedge after the accepting edge.
   task automatic applyStimulus(input bit sel, input logic [7:0] data);
      @(negedge clk);
      if (sel) begin
         pushIf7.tx_data  = data;
         pushIf7.tx_valid = 1'b1;
      end else begin
         pushIf.tx_data  = data;
         pushIf.tx_valid = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      pushIf.tx_valid  = 1'b0;
      pushIf7.tx_valid = 1'b0;
   endtask

   task automatic checkStart(input string tag, input bit sel);
      checkOutput({tag, "_lvl_acc"}, 32'(selLevel(sel)), 1);
      checkOutput({tag, "_busy_acc"}, 32'(selBusy(sel)), 0);
      @(negedge clk);
      checkOutput({tag, "_busy_pop"}, 32'(selBusy(sel)), 1);
      checkOutput({tag, "_lvl_pop"}, 32'(selLevel(sel)), 0);
      checkOutput({tag, "_txd_pop"}, 32'(selTxd(sel)), 1);
   endtask

   // Each bit must hold its level for exactly BPS sampled clocks.
   task automatic checkFrame(input string tag, input bit sel, input logic [11:0] bits,
                             input int nbits, input bit idleAfter, input bit toggleParity);
      int match;
      int busyCnt;
      busyCnt = 0;
      for (int b = 0; b < nbits; b++) begin
         match = 0;
         for (int c = 0; c < BPS; c++) begin
            @(negedge clk);
            if (selTxd(sel) === bits[b]) match++;
            if (selBusy(sel) === 1'b1) busyCnt++;
            if (toggleParity && b == 4 && c == 0) parityMode = ~parityMode;
         end
         checkOutput($sformatf("%s_bit%0d", tag, b), match, BPS);
      end
      checkOutput({tag, "_busy_len"}, busyCnt, idleAfter ? nbits * BPS - 1 : nbits * BPS);
      if (idleAfter) begin
         @(negedge clk);
         checkOutput({tag, "_txd_idle"}, 32'(selTxd(sel)), 1);
         checkOutput({tag, "_busy_idle"}, 32'(selBusy(sel)), 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lowCnt;
      int busyCnt;
      words = '{8'hA1, 8'h3C, 8'h5E, 8'h96, 8'h0F, 8'hC3, 8'h7B, 8'h24};
      pushIf.tx_data   = 8'h00;
      pushIf.tx_valid  = 1'b0;
      pushIf7.tx_data  = 8'h00;
      pushIf7.tx_valid = 1'b0;
      parityMode  = 2'b00;
      stopTwo     = 1'b0;
      parityMode7 = 2'b00;
      stopTwo7    = 1'b1;

      repeat (3) @(negedge clk);
      checkOutput("rst_txd", 32'(uartTxd), 1);
      checkOutput("rst_busy", 32'(txBusy), 0);
      checkOutput("rst_level", 32'(fifoLevel), 0);
      checkOutput("rst_ready", 32'(pushIf.tx_ready), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("idle_txd", 32'(uartTxd), 1);

      $display("[TB] 8N1 frame of 0x55");
      applyStimulus(1'b0, 8'h55);
      checkStart("t55", 1'b0);
      checkFrame("t55", 1'b0, 12'h2AA, 10, 1'b1, 1'b0);

      $display("[TB] even parity 0x07 with mid-frame parity change");
      parityMode = 2'b10;
      applyStimulus(1'b0, 8'h07);
      checkStart("even", 1'b0);
      checkFrame("even", 1'b0, 12'b011000001110, 11, 1'b1, 1'b1);

      $display("[TB] odd parity 0x07");
      parityMode = 2'b01;
      applyStimulus(1'b0, 8'h07);
      checkStart("odd", 1'b0);
      checkFrame("odd", 1'b0, 12'b010000001110, 11, 1'b1, 1'b0);

      $display("[TB] 7 data bits, two stop bits, 0xFF");
      applyStimulus(1'b1, 8'hFF);
      checkStart("d7", 1'b1);
      checkFrame("d7", 1'b1, 12'h3FE, 10, 1'b1, 1'b0);

      $display("[TB] FIFO full and back-to-back frames");
      parityMode = 2'b00;
      fork
         begin
            int  idx;
            logic readyNow;
            idx = 0;
            @(negedge clk);
            for (int c = 0; c < 8; c++) begin
               pushIf.tx_data  = words[idx];
               pushIf.tx_valid = 1'b1;
               readyNow = pushIf.tx_ready;
               @(posedge clk);
               @(negedge clk);
               if (readyNow) idx++;
            end
            checkOutput("full_accepted", idx, 5);
            checkOutput("full_ready", 32'(pushIf.tx_ready), 0);
            checkOutput("full_level", 32'(fifoLevel), 4);
            pushIf.tx_valid = 1'b0;
         end
         begin
            repeat (3) @(negedge clk);
            for (int k = 0; k < 5; k++) begin
               checkFrame($sformatf("fifo%0d", k), 1'b0, frameBits(words[k]), 10, k == 4, 1'b0);
               if (k == 0) begin
                  checkOutput("fifo_ready_rise", 32'(pushIf.tx_ready), 1);
                  checkOutput("fifo_level_3", 32'(fifoLevel), 3);
               end
            end
         end
      join

      $display("[TB] reset during the second of three queued frames");
      @(negedge clk);
      pushIf.tx_data  = 8'h00;
      pushIf.tx_valid = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      pushIf.tx_valid = 1'b0;
      repeat (498) @(negedge clk);
      checkOutput("rst_pre_txd", 32'(uartTxd), 0);
      checkOutput("rst_pre_level", 32'(fifoLevel), 1);
      checkOutput("rst_pre_busy", 32'(txBusy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_txd", 32'(uartTxd), 1);
      checkOutput("rst_mid_level", 32'(fifoLevel), 0);
      checkOutput("rst_mid_busy", 32'(txBusy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lowCnt  = 0;
      busyCnt = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (uartTxd !== 1'b1) lowCnt++;
         if (txBusy !== 1'b0) busyCnt++;
      end
      checkOutput("post_rst_txd_low", lowCnt, 0);
      checkOutput("post_rst_busy", busyCnt, 0);
      checkOutput("post_rst_level", 32'(fifoLevel), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
